mul_pipe_unit: RTL and testbench
================================

// Module: mul_pipe_unit
// PURPOSE
//  Parametrised, fully pipelined integer multiply unit for the EX stage; successor to the fixed-latency
//  IP-wrapper multiplier. Accepts one op per cycle under valid/ready handshake, supports signed/unsigned
//  and multiply-accumulate/subtract (MADD/MSUB-style). Has whole-pipe stall on backpressure and single-cycle
//  flush for exception/branch squash. Drives {hi,lo} for HI/LO writeback.
// PARAMETERS
//  W       32  operand width; result is 2*W bits
//  STAGES  3   pipeline depth = accept-to-out_valid latency in cycles, legal range 1..8
// PORTS
//  clk        in   1    clock, rising edge
//  rstn       in   1    synchronous reset, active-low
//  flush      in   1    squash all in-flight ops this cycle
//  in_valid   in   1    op present on inputs
//  in_ready   out  1    unit can accept op this cycle
//  sign       in   1    1 = signed (two's complement) operands, 0 = unsigned
//  acc_en     in   1    1 = accumulate with acc_in, 0 = plain multiply
//  acc_sub    in   1    with acc_en: 1 = acc_in - product, 0 = acc_in + product
//  srca       in   W    multiplicand
//  srcb       in   W    multiplier
//  acc_in     in   2W   accumulator {HI,LO}, sampled at accept
//  out_valid  out  1    result valid
//  out_ready  in   1    consumer takes result this cycle
//  hi         out  W    result[2W-1:W]
//  lo         out  W    result[W-1:0]
//  busy       out  1    any stage holds a valid op
// BEHAVIOUR
//  - Reset (rstn=0 at posedge): all stage valid bits 0; out_valid=0, busy=0, hi=lo=0. in_ready=0 while rstn=0.
//  - Accept when in_valid & in_ready. Operands, sign, acc_en, acc_sub, acc_in are captured on the same edge.
//  - advance = !out_valid | out_ready. in_ready = advance & rstn & !flush.
//    On advance all stages shift one step; otherwise every stage holds, including data.
//  - Latency: an op accepted at edge N gives out_valid=1 after edge N+STAGES-1+... , i.e. exactly STAGES
//    cycles after acceptance with no stall. Each stall cycle adds one. Throughput is 1 op/cycle. Order is preserved.
//  - Result held stable while out_valid & !out_ready.
//  - Arithmetic: each operand is extended to W+1 bits (sign-extended if sign, else zero-extended).
//    Product P = low 2W bits of the full product.
//    acc_en=0: R=P. acc_en=1: R = acc_in + P (acc_sub=0) or acc_in - P (acc_sub=1), modulo 2^(2W).
//    No overflow flag.
//  - Pipeline register placement is free, provided the result is bit-exact.
//  - flush: on the edge with flush=1 all valid bits clear, including the output stage. Any in_valid that
//    cycle is not accepted. Next cycle out_valid=0, busy=0. flush overrides stall.
//  - Reset mid-operation: identical to flush; data registers need not clear but hi/lo must read 0 after reset.
//  - Simultaneous output handshake and new accept under stall release: both occur on the same edge, no bubble.
//  - out_valid and hi/lo are driven from registers, with no combinational path from inputs.
//    in_ready depends combinationally only on out_ready, out_valid, flush and rstn.
// TESTING (W=32, STAGES=3 unless noted)
//  1. Unsigned: srca=0xFFFFFFFF, srcb=0xFFFFFFFF, sign=0 -> 3 cycles later hi=0xFFFFFFFE, lo=0x00000001.
//  2. Signed: srca=0xFFFFFFFF (-1), srcb=0x00000002, sign=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
//     Same op with sign=0 -> hi=0x00000001, lo=0xFFFFFFFE.
//  3. MSUB: acc_in=0x0000000000000005, srca=3, srcb=2, acc_en=1, acc_sub=1, sign=1 -> hi=0xFFFFFFFF,
//     lo=0xFFFFFFFF. MADD wrap: acc_in=0xFFFFFFFFFFFFFFFF, srca=1, srcb=1 -> hi=lo=0.
//  4. Back-to-back: 8 ops on consecutive cycles with out_ready=1 -> 8 results on consecutive cycles,
//     in order, first at cycle 3.
//  5. Backpressure: out_ready=0 for 5 cycles with pipe full -> in_ready=0, hi/lo stable, nothing lost.
//     On release results resume one per cycle.
//  6. Flush with 3 ops in flight plus in_valid=1 -> next cycle out_valid=0, busy=0, no result from any
//     of the 4 ops. Repeat with rstn=0 mid-stream -> outputs 0. Rerun tests 1-4 with STAGES=1 and STAGES=8.

Source files
------------

// File: rtl/mul_pipe_unit.sv
// Pipelined signed/unsigned multiply with optional accumulate/subtract.
// Whole-pipe stall on backpressure, single-cycle flush, {hi,lo} result.
module mul_pipe_unit #(
    parameter int W      = 32,
    parameter int STAGES = 3
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            sign,
    input  logic            acc_en,
    input  logic            acc_sub,
    input  logic [W-1:0]    srca,
    input  logic [W-1:0]    srcb,
    input  logic [2*W-1:0]  acc_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    hi,
    output logic [W-1:0]    lo,
    output logic            busy
);

    localparam int DW = 2 * W;

    logic                         adv;
    logic                         take;
    logic [STAGES-1:0]            vld_q;
    logic [STAGES-1:0]            vld_d;
    logic [STAGES-1:0][DW-1:0]    dat_q;
    logic [STAGES-1:0][DW-1:0]    dat_d;
    logic [STAGES-1:0][DW-1:0]    stg_in;
    logic [DW-1:0]                a_x;
    logic [DW-1:0]                b_x;
    logic [DW-1:0]                prod;

    function automatic logic [DW-1:0] fin(
        input logic [DW-1:0] p,
        input logic [DW-1:0] a,
        input logic          en,
        input logic          sub
    );
        if (!en) begin
            return p;
        end else if (sub) begin
            return a - p;
        end else begin
            return a + p;
        end
    endfunction

    assign out_valid = vld_q[STAGES-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv && rstn && !flush;
    assign take      = in_valid && in_ready;
    assign busy      = |vld_q;
    assign hi        = dat_q[STAGES-1][DW-1:W];
    assign lo        = dat_q[STAGES-1][W-1:0];

    // Low 2W bits of the (W+1)x(W+1) product only depend on the
    // operands extended to 2W, so a plain 2W-bit multiply is exact.
    always_comb begin
        a_x  = sign ? {{W{srca[W-1]}}, srca} : {{W{1'b0}}, srca};
        b_x  = sign ? {{W{srcb[W-1]}}, srcb} : {{W{1'b0}}, srcb};
        prod = a_x * b_x;
    end

    generate
        if (STAGES == 1) begin : g_one
            assign stg_in[0] = fin(prod, acc_in, acc_en, acc_sub);
        end else begin : g_multi
            logic [DW-1:0] acc_q;
            logic [DW-1:0] acc_d;
            logic          en_q;
            logic          en_d;
            logic          sub_q;
            logic          sub_d;

            always_comb begin
                acc_d = acc_q;
                en_d  = en_q;
                sub_d = sub_q;
                if (adv && take) begin
                    acc_d = acc_in;
                    en_d  = acc_en;
                    sub_d = acc_sub;
                end
            end

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    acc_q <= '0;
                    en_q  <= 1'b0;
                    sub_q <= 1'b0;
                end else begin
                    acc_q <= acc_d;
                    en_q  <= en_d;
                    sub_q <= sub_d;
                end
            end

            // Product registered first, accumulate folded in on the next hop.
            assign stg_in[0] = prod;
            assign stg_in[1] = fin(dat_q[0], acc_q, en_q, sub_q);

            for (genvar i = 2; i < STAGES; i++) begin : g_fwd
                assign stg_in[i] = dat_q[i-1];
            end
        end
    endgenerate

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (adv) begin
            vld_d[0] = take;
            if (take) begin
                dat_d[0] = stg_in[0];
            end
            for (int i = 1; i < STAGES; i++) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_d[i] = stg_in[i];
                end
            end
        end
        if (flush) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Directed bench for mul_pipe_unit at STAGES 3, 1 and 8 side by side.
module tb_mul_pipe_unit;

    localparam int ST [3] = '{3, 1, 8};

    logic              clk;
    logic              rstn;
    logic              flush;
    logic              in_valid;
    logic              sign;
    logic              acc_en;
    logic              acc_sub;
    logic [31:0]       srca;
    logic [31:0]       srcb;
    logic [63:0]       acc_in;
    logic              out_ready;
    logic [2:0]        rdy;
    logic [2:0]        ov;
    logic [2:0]        bsy;
    logic [2:0][31:0]  hi;
    logic [2:0][31:0]  lo;

    int total;
    int bad;

    logic [63:0] e8 [8];
    logic [63:0] e5 [5];

    mul_pipe_unit #(.W(32), .STAGES(3)) u_s3 (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy[0]), .sign(sign), .acc_en(acc_en), .acc_sub(acc_sub),
        .srca(srca), .srcb(srcb), .acc_in(acc_in), .out_valid(ov[0]),
        .out_ready(out_ready), .hi(hi[0]), .lo(lo[0]), .busy(bsy[0])
    );

    mul_pipe_unit #(.W(32), .STAGES(1)) u_s1 (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy[1]), .sign(sign), .acc_en(acc_en), .acc_sub(acc_sub),
        .srca(srca), .srcb(srcb), .acc_in(acc_in), .out_valid(ov[1]),
        .out_ready(out_ready), .hi(hi[1]), .lo(lo[1]), .busy(bsy[1])
    );

    mul_pipe_unit #(.W(32), .STAGES(8)) u_s8 (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy[2]), .sign(sign), .acc_en(acc_en), .acc_sub(acc_sub),
        .srca(srca), .srcb(srcb), .acc_in(acc_in), .out_valid(ov[2]),
        .out_ready(out_ready), .hi(hi[2]), .lo(lo[2]), .busy(bsy[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tg, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tg, got, exp);
        end
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        sign     = 1'b0;
        acc_en   = 1'b0;
        acc_sub  = 1'b0;
        srca     = a;
        srcb     = b;
        acc_in   = 64'h0;
    endtask

    task automatic single(input string tg, input logic sg,
                          input logic en, input logic sb,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] ac, input logic [63:0] ex);
        in_valid = 1'b1;
        sign     = sg;
        acc_en   = en;
        acc_sub  = sb;
        srca     = a;
        srcb     = b;
        acc_in   = ac;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("%s ov s%0d k%0d", tg, ST[d], k),
                    64'(ov[d]), 64'(k == ST[d]));
                if (k == ST[d]) begin
                    chk($sformatf("%s res s%0d", tg, ST[d]),
                        {hi[d], lo[d]}, ex);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rstn      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        sign      = 1'b0;
        acc_en    = 1'b0;
        acc_sub   = 1'b0;
        srca      = 32'h0;
        srcb      = 32'h0;
        acc_in    = 64'h0;
        out_ready = 1'b1;

        for (int i = 0; i < 8; i++) begin
            e8[i] = {32'h0, 32'hF000_0000 + 32'(i)} *
                    {32'h0, 32'h0000_0010 * 32'(i + 1)};
        end
        for (int i = 0; i < 5; i++) begin
            e5[i] = {32'h0, 32'h1234_0000 + 32'(i) * 32'h1111} *
                    {32'h0, 32'h0000_ABCD + 32'(i)};
        end

        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst rdy s%0d", ST[d]), 64'(rdy[d]), 64'h0);
            chk($sformatf("rst ov s%0d", ST[d]), 64'(ov[d]), 64'h0);
            chk($sformatf("rst busy s%0d", ST[d]), 64'(bsy[d]), 64'h0);
            chk($sformatf("rst res s%0d", ST[d]), {hi[d], lo[d]}, 64'h0);
        end
        rstn = 1'b1;
        @(negedge clk);
        chk("idle rdy", 64'(rdy[0]), 64'h1);

        single("umul", 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'h0, 64'hFFFF_FFFE_0000_0001);
        single("smul", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002,
               64'h0, 64'hFFFF_FFFF_FFFF_FFFE);
        single("smul_u", 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002,
               64'h0, 64'h0000_0001_FFFF_FFFE);
        single("msub", 1'b1, 1'b1, 1'b1, 32'h3, 32'h2,
               64'h5, 64'hFFFF_FFFF_FFFF_FFFF);
        single("madd_wrap", 1'b0, 1'b1, 1'b0, 32'h1, 32'h1,
               64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        single("madd_neg", 1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h3,
               64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0000);

        for (int c = 0; c <= 17; c++) begin
            chk($sformatf("b2b rdy c%0d", c), 64'(rdy[0]), 64'h1);
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("b2b ov s%0d c%0d", ST[d], c), 64'(ov[d]),
                    64'(c >= ST[d] && c < ST[d] + 8));
                if (c >= ST[d] && c < ST[d] + 8) begin
                    chk($sformatf("b2b res s%0d c%0d", ST[d], c),
                        {hi[d], lo[d]}, e8[c-ST[d]]);
                end
            end
            if (c < 8) begin
                set_op(32'hF000_0000 + 32'(c), 32'h0000_0010 * 32'(c + 1));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end

        for (int c = 0; c <= 13; c++) begin
            chk($sformatf("bp ov c%0d", c), 64'(ov[0]),
                64'(c >= 3 && c <= 12));
            chk($sformatf("bp rdy c%0d", c), 64'(rdy[0]),
                64'(c < 3 || c > 8));
            if (c >= 3 && c <= 8) begin
                chk($sformatf("bp hold c%0d", c), {hi[0], lo[0]}, e5[0]);
            end
            if (c >= 9 && c <= 12) begin
                chk($sformatf("bp res c%0d", c), {hi[0], lo[0]}, e5[c-8]);
            end
            out_ready = (c >= 8);
            if (c <= 9) begin
                set_op(32'h1234_0000 + 32'(c > 3 ? (c == 9 ? 4 : 3) : c) * 32'h1111,
                       32'h0000_ABCD + 32'(c > 3 ? (c == 9 ? 4 : 3) : c));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (12) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("drain busy s%0d", ST[d]), 64'(bsy[d]), 64'h0);
        end

        for (int c = 0; c < 3; c++) begin
            set_op(32'h0000_0100 + 32'(c), 32'h0000_0007);
            @(negedge clk);
        end
        chk("fl pre ov", 64'(ov[0]), 64'h1);
        chk("fl pre busy", 64'(bsy[0]), 64'h1);
        flush = 1'b1;
        set_op(32'h0000_0200, 32'h0000_0009);
        #1;
        chk("fl rdy", 64'(rdy[0]), 64'h0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("fl ov s%0d c%0d", ST[d], c), 64'(ov[d]), 64'h0);
                chk($sformatf("fl busy s%0d c%0d", ST[d], c), 64'(bsy[d]), 64'h0);
            end
            @(negedge clk);
        end

        for (int c = 0; c < 2; c++) begin
            set_op(32'h0000_0300 + 32'(c), 32'h0000_0005);
            @(negedge clk);
        end
        rstn = 1'b0;
        set_op(32'h0000_0400, 32'h0000_0003);
        #1;
        chk("mrst rdy", 64'(rdy[0]), 64'h0);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("mrst ov s%0d", ST[d]), 64'(ov[d]), 64'h0);
            chk($sformatf("mrst busy s%0d", ST[d]), 64'(bsy[d]), 64'h0);
            chk($sformatf("mrst res s%0d", ST[d]), {hi[d], lo[d]}, 64'h0);
            chk($sformatf("mrst rdy s%0d", ST[d]), 64'(rdy[d]), 64'h0);
        end
        rstn     = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("post ov s%0d", ST[d]), 64'(ov[d]), 64'h0);
            chk($sformatf("post res s%0d", ST[d]), {hi[d], lo[d]}, 64'h0);
        end
        single("again", 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'h0, 64'hFFFF_FFFE_0000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
